// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU load path: load opcodes, load FSM states and
// the byte-lane enable generator.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    LB        = 3'd0,
    LBU       = 3'd1,
    LH        = 3'd2,
    LHU       = 3'd3,
    LW        = 3'd4,
    LWL       = 3'd5,
    LWR       = 3'd6,
    LOAD_RSVD = 3'd7
  } load_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WB   = 2'd2
  } load_state_t;

  // Byte lanes touched on the little-endian bus for a given op and addr[1:0].
  function automatic logic [3:0] load_byteenable(input load_op_t op, input logic [1:0] b);
    logic [3:0] be;
    case (op)
      LB, LBU: be = 4'b0001 << b;
      LH, LHU: be = b[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Combinational load-data alignment: byte/half extraction with sign or zero
// extension, and the shifted data plus merge controls for LWL/LWR.
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  load_op_t    op,
  input  logic [1:0]  b,
  input  logic [31:0] d,
  output logic [31:0] data,
  output logic        orwrite,
  output logic [1:0]  shiftdata,
  output logic        loadlorloadr
);

  logic [31:0]        shr;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // The addressed byte/half always lands in the low bits after this shift.
  assign shr    = d >> {b, 3'b000};
  assign byte_s = shr[7:0];
  assign half_s = shr[15:0];

  always_comb begin
    data         = '0;
    orwrite      = 1'b0;
    shiftdata    = 2'd0;
    loadlorloadr = 1'b0;
    case (op)
      LB:  data = {{24{byte_s[7]}}, byte_s};
      LBU: data = {24'd0, byte_s};
      LH:  data = {{16{half_s[15]}}, half_s};
      LHU: data = {16'd0, half_s};
      LW:  data = d;
      LWL: begin
        // ~b equals 3-b for a 2-bit offset.
        data      = d << {~b, 3'b000};
        orwrite   = 1'b1;
        shiftdata = ~b;
      end
      LWR: begin
        data         = shr;
        orwrite      = 1'b1;
        shiftdata    = ~b;
        loadlorloadr = 1'b1;
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_load_unit.sv
// Multi-cycle load stage: issues one word-aligned Avalon-MM read per request
// and emits a single-cycle register-file write with LWL/LWR merge controls.
module mips_cpu_load_unit
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_dest,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        rf_orwrite,
  output logic [1:0]  rf_shiftdata,
  output logic        rf_loadlorloadr,
  output logic        load_error,
  output logic        busy
);

  load_state_t state;
  load_op_t    req_op_e;
  load_op_t    op_p0;
  logic [1:0]  b_p0;
  logic [4:0]  dest_p0;
  logic        req_err;

  logic [31:0] al_data;
  logic        al_orwrite;
  logic [1:0]  al_shiftdata;
  logic        al_loadlorloadr;

  assign req_op_e  = load_op_t'(req_op);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign avm_read  = (state == READ);

  always_comb begin
    case (req_op_e)
      LH, LHU:   req_err = req_addr[0];
      LW:        req_err = (req_addr[1:0] != 2'b00);
      LOAD_RSVD: req_err = 1'b1;
      default:   req_err = 1'b0;
    endcase
  end

  mips_cpu_load_align u_align (
    .op           (op_p0),
    .b            (b_p0),
    .d            (avm_readdata),
    .data         (al_data),
    .orwrite      (al_orwrite),
    .shiftdata    (al_shiftdata),
    .loadlorloadr (al_loadlorloadr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      op_p0           <= LB;
      b_p0            <= 2'd0;
      dest_p0         <= 5'd0;
      avm_address     <= '0;
      avm_byteenable  <= '0;
      load_error      <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
      rf_orwrite      <= 1'b0;
      rf_shiftdata    <= '0;
      rf_loadlorloadr <= 1'b0;
    end else begin
      // rf_* and load_error are pulses; they fall back to zero unless set below.
      load_error      <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
      rf_orwrite      <= 1'b0;
      rf_shiftdata    <= '0;
      rf_loadlorloadr <= 1'b0;
      case (state)
        // IDLE -> READ: accept and latch the request
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              load_error <= 1'b1;
            end else begin
              op_p0          <= req_op_e;
              b_p0           <= req_addr[1:0];
              dest_p0        <= req_dest;
              avm_address    <= {req_addr[31:2], 2'b00};
              avm_byteenable <= load_byteenable(req_op_e, req_addr[1:0]);
              state          <= READ;
            end
          end
        end
        // READ -> WB: capture aligned data straight into the rf registers
        READ: begin
          if (!avm_waitrequest) begin
            rf_write_enable <= (dest_p0 != 5'd0);
            rf_write_reg    <= dest_p0;
            rf_write_data   <= al_data;
            rf_orwrite      <= al_orwrite;
            rf_shiftdata    <= al_shiftdata;
            rf_loadlorloadr <= al_loadlorloadr;
            state           <= WB;
          end
        end
        // WB -> IDLE: write lasts one cycle
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_load_unit.sv
// Directed self-checking bench for mips_cpu_load_unit.
module tb_mips_cpu_load_unit;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [4:0]  req_dest;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_orwrite;
  logic [1:0]  rf_shiftdata;
  logic        rf_loadlorloadr;
  logic        load_error;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mips_cpu_load_unit dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_dest        (req_dest),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .rf_orwrite      (rf_orwrite),
    .rf_shiftdata    (rf_shiftdata),
    .rf_loadlorloadr (rf_loadlorloadr),
    .load_error      (load_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " avm_read"}, 32'(avm_read), 32'd0);
    chk({tag, " rf_we"}, 32'(rf_write_enable), 32'd0);
    chk({tag, " rf_data"}, rf_write_data, 32'd0);
    chk({tag, " rf_or"}, 32'(rf_orwrite), 32'd0);
    chk({tag, " rf_shift"}, 32'(rf_shiftdata), 32'd0);
    chk({tag, " rf_lr"}, 32'(rf_loadlorloadr), 32'd0);
  endtask

  // One full load: accept, w wait cycles, capture, WB, back to IDLE.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [4:0] dest, input logic [31:0] rdata, input int waits,
                         input logic [3:0] exp_be, input logic [31:0] exp_data,
                         input logic exp_or, input logic [1:0] exp_shift,
                         input logic exp_lr, input logic exp_we);
    req_valid       = 1'b1;
    req_op          = op;
    req_addr        = addr;
    req_dest        = dest;
    avm_waitrequest = (waits > 0);
    avm_readdata    = (waits > 0) ? 32'hDEAD_BEEF : rdata;
    tick();
    req_valid = 1'b0;
    chk({tag, " ready_low"}, 32'(req_ready), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < waits; k++) begin
      chk({tag, " read_held"}, 32'(avm_read), 32'd1);
      chk({tag, " addr"}, avm_address, {addr[31:2], 2'b00});
      chk({tag, " be"}, 32'(avm_byteenable), 32'(exp_be));
      tick();
      if (k == waits - 1) begin
        avm_waitrequest = 1'b0;
        avm_readdata    = rdata;
      end
    end
    chk({tag, " read"}, 32'(avm_read), 32'd1);
    chk({tag, " addr"}, avm_address, {addr[31:2], 2'b00});
    chk({tag, " be"}, 32'(avm_byteenable), 32'(exp_be));
    chk({tag, " no_early_we"}, 32'(rf_write_enable), 32'd0);
    tick();
    avm_readdata = 32'h5A5A_5A5A;
    chk({tag, " read_dropped"}, 32'(avm_read), 32'd0);
    chk({tag, " we"}, 32'(rf_write_enable), 32'(exp_we));
    chk({tag, " reg"}, 32'(rf_write_reg), 32'(dest));
    chk({tag, " data"}, rf_write_data, exp_data);
    chk({tag, " or"}, 32'(rf_orwrite), 32'(exp_or));
    chk({tag, " shift"}, 32'(rf_shiftdata), 32'(exp_shift));
    chk({tag, " lr"}, 32'(rf_loadlorloadr), 32'(exp_lr));
    tick();
    check_idle_outputs({tag, " after"});
  endtask

  task automatic do_error(input string tag, input logic [2:0] op, input logic [31:0] addr);
    req_valid       = 1'b1;
    req_op          = op;
    req_addr        = addr;
    req_dest        = 5'd3;
    avm_waitrequest = 1'b0;
    tick();
    req_valid = 1'b0;
    chk({tag, " err_pulse"}, 32'(load_error), 32'd1);
    chk({tag, " no_read"}, 32'(avm_read), 32'd0);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, " err_clear"}, 32'(load_error), 32'd0);
    chk({tag, " no_read2"}, 32'(avm_read), 32'd0);
    chk({tag, " no_we"}, 32'(rf_write_enable), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_op          = 3'd0;
    req_addr        = 32'd0;
    req_dest        = 5'd0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    tick();
    tick();
    check_idle_outputs("reset");
    chk("reset addr", avm_address, 32'd0);
    chk("reset be", 32'(avm_byteenable), 32'd0);
    chk("reset err", 32'(load_error), 32'd0);
    chk("reset reg", 32'(rf_write_reg), 32'd0);
    reset = 1'b0;
    tick();

    do_load("lb_1003",  LB,  32'h0000_1003, 5'd1, 32'h80FF_0000, 0, 4'b1000, 32'hFFFF_FF80, 1'b0, 2'd0, 1'b0, 1'b1);
    do_load("lhu_2002", LHU, 32'h0000_2002, 5'd2, 32'hBEEF_1234, 3, 4'b1100, 32'h0000_BEEF, 1'b0, 2'd0, 1'b0, 1'b1);
    do_load("lwl_3001", LWL, 32'h0000_3001, 5'd3, 32'h4433_2211, 0, 4'b1111, 32'h2211_0000, 1'b1, 2'd2, 1'b0, 1'b1);
    do_load("lwr_3001", LWR, 32'h0000_3001, 5'd4, 32'h4433_2211, 1, 4'b1111, 32'h0044_3322, 1'b1, 2'd2, 1'b1, 1'b1);
    do_load("lbu_1001", LBU, 32'h0000_1001, 5'd5, 32'h1234_A5F0, 0, 4'b0010, 32'h0000_00A5, 1'b0, 2'd0, 1'b0, 1'b1);
    do_load("lb_1001",  LB,  32'h0000_1001, 5'd6, 32'h1234_A5F0, 0, 4'b0010, 32'hFFFF_FFA5, 1'b0, 2'd0, 1'b0, 1'b1);
    do_load("lh_5000",  LH,  32'h0000_5000, 5'd7, 32'h0000_8001, 2, 4'b0011, 32'hFFFF_8001, 1'b0, 2'd0, 1'b0, 1'b1);
    do_load("lw_dest0", LW,  32'h0000_6000, 5'd0, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D, 1'b0, 2'd0, 1'b0, 1'b0);
    do_load("lwr_7000", LWR, 32'h0000_7000, 5'd8, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, 1'b1, 2'd3, 1'b1, 1'b1);
    do_load("lwl_7003", LWL, 32'h0000_7003, 5'd9, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, 1'b1, 2'd0, 1'b0, 1'b1);

    do_error("lw_4002",  LW,        32'h0000_4002);
    do_error("lh_odd",   LH,        32'h0000_4001);
    do_error("reserved", LOAD_RSVD, 32'h0000_4000);

    // Reset while stalled in READ discards the load.
    req_valid       = 1'b1;
    req_op          = LB;
    req_addr        = 32'h0000_8000;
    req_dest        = 5'd10;
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'h0000_00FF;
    tick();
    req_valid = 1'b0;
    chk("rst_read read", 32'(avm_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    chk("rst_read read_off", 32'(avm_read), 32'd0);
    chk("rst_read busy", 32'(busy), 32'd0);
    chk("rst_read we", 32'(rf_write_enable), 32'd0);
    tick();
    chk("rst_read no_we", 32'(rf_write_enable), 32'd0);
    chk("rst_read no_read", 32'(avm_read), 32'd0);
    do_load("post_rst", LHU, 32'h0000_9000, 5'd11, 32'h1234_5678, 0, 4'b0011, 32'h0000_5678, 1'b0, 2'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
